// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard control for a 5-stage pipeline. The block
// shadows the destination/control fields of the instructions in EX, MEM and WB.
// From those it drives the select codes for the two EX-stage ALU operand muxes.
// It also raises the load-use stall from the ID-stage source fields. The top
// level only presents ID fields and the squash request.
//
// Operand mux select encoding:
//   00 : register-file value
//   01 : MEM/WB result
//   10 : EX/MEM result
//   11 : never driven
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-low reset
//   id_rs_i         rs of the instruction in ID
//   id_rt_i         rt of the instruction in ID
//   id_uses_rt_i    ID instruction reads rt as a source
//   id_rd_i         final destination register of the ID instruction
//   id_reg_write_i  ID instruction writes the register file
//   id_mem_read_i   ID instruction is a load
//   flush_i         squash the ID instruction (taken branch/jump)
//   fwd_a_o         select for ALU operand A mux
//   fwd_b_o         select for ALU operand B mux
//   stall_o         hold PC and IF/ID, bubble into EX
//   stall_cnt_o     saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [1:0]       SEL_RF  = 2'b00;
  localparam logic [1:0]       SEL_WB  = 2'b01;
  localparam logic [1:0]       SEL_MEM = 2'b10;
  localparam reg_addr_t        REG_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // EX stage
  reg_addr_t ex_rs;
  reg_addr_t ex_rt;
  reg_addr_t ex_rd;
  logic      ex_rw;
  logic      ex_mr;

  // MEM stage
  reg_addr_t mem_rd;
  logic      mem_rw;
  logic      mem_mr;

  // WB stage
  reg_addr_t wb_rd;
  logic      wb_rw;

  logic [CNT_W-1:0] stall_cnt;
  logic             ex_bubble;

  logic mem_hit_a;
  logic mem_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;
  logic load_hit_rs;
  logic load_hit_rt;

  // A stall and a flush in the same cycle both just mean "no instruction
  // enters EX", so they collapse into a single bubble.
  assign ex_bubble = stall_o | flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_rw <= 1'b0;
      ex_mr <= 1'b0;
    end else if (ex_bubble) begin
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_rw <= 1'b0;
      ex_mr <= 1'b0;
    end else begin
      ex_rs <= id_rs_i;
      ex_rt <= id_rt_i;
      ex_rd <= id_rd_i;
      ex_rw <= id_reg_write_i;
      ex_mr <= id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_rd <= '0;
      mem_rw <= 1'b0;
      mem_mr <= 1'b0;
      wb_rd  <= '0;
      wb_rw  <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      mem_mr <= ex_mr;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
    end
  end

  // Register 0 is hard-wired, so a "write" to it must never be forwarded.
  assign mem_hit_a = mem_rw && (mem_rd != REG_ZERO) && (mem_rd == ex_rs);
  assign mem_hit_b = mem_rw && (mem_rd != REG_ZERO) && (mem_rd == ex_rt);
  assign wb_hit_a  = wb_rw  && (wb_rd  != REG_ZERO) && (wb_rd  == ex_rs);
  assign wb_hit_b  = wb_rw  && (wb_rd  != REG_ZERO) && (wb_rd  == ex_rt);

  // EX/MEM holds the younger producer, so it wins over MEM/WB.
  // Operand B is resolved even for immediate-form instructions; the ALUSrc
  // mux after the forwarding mux throws the value away in that case.
  always_comb begin
    fwd_a_o = SEL_RF;
    if (mem_hit_a) begin
      fwd_a_o = SEL_MEM;
    end else if (wb_hit_a) begin
      fwd_a_o = SEL_WB;
    end
  end

  always_comb begin
    fwd_b_o = SEL_RF;
    if (mem_hit_b) begin
      fwd_b_o = SEL_MEM;
    end else if (wb_hit_b) begin
      fwd_b_o = SEL_WB;
    end
  end

  // A load in EX has no data until the end of MEM. A consumer in ID must
  // wait one cycle and then picks the value up from MEM/WB. The bubble
  // clears ex_mr, so a single load never stalls for two cycles in a row.
  assign load_hit_rs = (ex_rd == id_rs_i);
  assign load_hit_rt = id_uses_rt_i && (ex_rd == id_rt_i);
  assign stall_o     = ex_mr && (ex_rd != REG_ZERO) && (load_hit_rs || load_hit_rt);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt;

  // A load in MEM has only its address on the EX/MEM bus. Because of the
  // stall, no rs consumer of that load can be sitting in EX behind it.
  load_in_mem_not_forwarded : assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (mem_mr && (mem_rd != REG_ZERO)) |-> (ex_rs != mem_rd)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed bench for fwd_hazard_ctrl. Instruction sequences are fed into the
// ID fields one per cycle. Selects, stall and stall count are compared against
// hand-derived values once the instruction of interest sits in EX. A second
// instance with a 4-bit counter shares all inputs and covers saturation.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int RAW = 5;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [RAW-1:0] id_rs_i;
  logic [RAW-1:0] id_rt_i;
  logic           id_uses_rt_i;
  logic [RAW-1:0] id_rd_i;
  logic           id_reg_write_i;
  logic           id_mem_read_i;
  logic           flush_i;

  logic [1:0]     fwd_a_o;
  logic [1:0]     fwd_b_o;
  logic           stall_o;
  logic [15:0]    stall_cnt_o;

  logic [1:0]     sat_fwd_a;
  logic [1:0]     sat_fwd_b;
  logic           sat_stall;
  logic [3:0]     sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl #(.REG_ADDR_W(RAW), .CNT_W(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .id_rd_i        (id_rd_i),
    .id_reg_write_i (id_reg_write_i),
    .id_mem_read_i  (id_mem_read_i),
    .flush_i        (flush_i),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o),
    .stall_o        (stall_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(RAW), .CNT_W(4)) dut_sat (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .id_rd_i        (id_rd_i),
    .id_reg_write_i (id_reg_write_i),
    .id_mem_read_i  (id_mem_read_i),
    .flush_i        (flush_i),
    .fwd_a_o        (sat_fwd_a),
    .fwd_b_o        (sat_fwd_b),
    .stall_o        (sat_stall),
    .stall_cnt_o    (sat_cnt)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input int rs, input int rt, input int uses_rt,
                        input int rd, input int rw, input int mr);
    id_rs_i        = RAW'(rs);
    id_rt_i        = RAW'(rt);
    id_uses_rt_i   = (uses_rt != 0);
    id_rd_i        = RAW'(rd);
    id_reg_write_i = (rw != 0);
    id_mem_read_i  = (mr != 0);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_sel(input string tag, input int a, input int b);
    check_val({tag, "_fwd_a"}, int'(fwd_a_o), a);
    check_val({tag, "_fwd_b"}, int'(fwd_b_o), b);
  endtask

  initial begin
    rst_i   = 1'b0;
    flush_i = 1'b0;
    nop();

    // Reset held with random ID traffic
    for (int i = 0; i < 3; i++) begin
      id_rs_i        = RAW'($urandom);
      id_rt_i        = RAW'($urandom);
      id_uses_rt_i   = 1'($urandom);
      id_rd_i        = RAW'($urandom);
      id_reg_write_i = 1'($urandom);
      id_mem_read_i  = 1'($urandom);
      flush_i        = 1'($urandom);
      tick();
      check_sel("rst_hold", 0, 0);
      check_val("rst_hold_stall", int'(stall_o), 0);
      check_val("rst_hold_cnt", int'(stall_cnt_o), 0);
    end
    flush_i = 1'b0;
    nop();
    rst_i = 1'b1;
    tick();

    // add $3 ; sub $5,$3,$3
    set_id(1, 2, 1, 3, 1, 0);
    tick();
    set_id(3, 3, 1, 5, 1, 0);
    settle();
    check_val("alu_dep_nostall", int'(stall_o), 0);
    tick();
    nop();
    settle();
    check_sel("alu_dep_mem", 2, 2);

    // add $3 ; or $8 ; sub $5,$3,$3
    set_id(1, 2, 1, 3, 1, 0);
    tick();
    set_id(1, 2, 1, 8, 1, 0);
    tick();
    set_id(3, 3, 1, 5, 1, 0);
    tick();
    nop();
    settle();
    check_sel("alu_dep_wb", 1, 1);

    // add $3 ; add $3 ; or $6,$3,$0
    set_id(1, 2, 1, 3, 1, 0);
    tick();
    set_id(4, 5, 1, 3, 1, 0);
    tick();
    set_id(3, 0, 1, 6, 1, 0);
    tick();
    nop();
    settle();
    check_sel("priority", 2, 0);

    // lw $4 ; add $7,$4,$2
    set_id(1, 4, 0, 4, 1, 1);
    settle();
    check_val("lu_lw_id_stall", int'(stall_o), 0);
    tick();
    set_id(4, 2, 1, 7, 1, 0);
    settle();
    check_val("lu_stall", int'(stall_o), 1);
    check_val("lu_cnt_before", int'(stall_cnt_o), 0);
    tick();
    settle();
    check_val("lu_stall_drop", int'(stall_o), 0);
    check_val("lu_cnt_after", int'(stall_cnt_o), 1);
    check_val("lu_bubble_fwd_a", int'(fwd_a_o), 0);
    tick();
    nop();
    settle();
    check_sel("lu_consumer", 1, 0);
    check_val("lu_consumer_cnt", int'(stall_cnt_o), 1);

    // lw $4 ; addi $7,$2,4 (rt is not a source)
    set_id(1, 4, 0, 4, 1, 1);
    tick();
    set_id(2, 4, 0, 7, 1, 0);
    settle();
    check_val("lu_imm_nostall", int'(stall_o), 0);
    tick();
    nop();
    settle();
    check_sel("lu_imm", 0, 2);
    check_val("lu_imm_cnt", int'(stall_cnt_o), 1);

    // add $0 ; add $0 ; or $9,$0,$0
    set_id(1, 2, 1, 0, 1, 0);
    tick();
    set_id(1, 2, 1, 0, 1, 0);
    tick();
    set_id(0, 0, 1, 9, 1, 0);
    tick();
    nop();
    settle();
    check_sel("reg0", 0, 0);

    // lw $0 ; reader of $0
    set_id(1, 0, 0, 0, 1, 1);
    tick();
    set_id(0, 0, 1, 10, 1, 0);
    settle();
    check_val("reg0_load_nostall", int'(stall_o), 0);
    tick();

    // flushed lw $4 ; add $11,$4,$4
    set_id(1, 4, 0, 4, 1, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_id(4, 4, 1, 11, 1, 0);
    settle();
    check_val("flush_nostall", int'(stall_o), 0);
    tick();
    nop();
    settle();
    check_sel("flush", 0, 0);

    // lw $4 ; consumer squashed while stalling ; or $13,$4,$4
    set_id(1, 4, 0, 4, 1, 1);
    tick();
    set_id(4, 4, 1, 12, 1, 0);
    flush_i = 1'b1;
    settle();
    check_val("flush_stall", int'(stall_o), 1);
    tick();
    flush_i = 1'b0;
    set_id(4, 4, 1, 13, 1, 0);
    settle();
    check_val("flush_stall_drop", int'(stall_o), 0);
    check_val("flush_stall_cnt", int'(stall_cnt_o), 2);
    tick();
    nop();
    settle();
    check_sel("flush_stall_after", 1, 1);

    // Reset asserted mid-stream, checked before the next edge
    settle();
    rst_i = 1'b0;
    settle();
    check_sel("rst_mid", 0, 0);
    check_val("rst_mid_stall", int'(stall_o), 0);
    check_val("rst_mid_cnt", int'(stall_cnt_o), 0);
    check_val("rst_mid_sat_cnt", int'(sat_cnt), 0);
    tick();
    rst_i = 1'b1;

    // Back-to-back dependent loads stall on every other edge
    set_id(4, 4, 0, 4, 1, 1);
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 14) begin
        check_val("sat_cnt_14", int'(sat_cnt), 7);
      end
      if (i == 30) begin
        check_val("sat_cnt_30", int'(sat_cnt), 15);
        check_val("sat_main_30", int'(stall_cnt_o), 15);
      end
      if (i == 32) begin
        check_val("sat_cnt_32", int'(sat_cnt), 15);
        check_val("sat_main_32", int'(stall_cnt_o), 16);
      end
      if (i == 34) begin
        check_val("sat_cnt_34", int'(sat_cnt), 15);
        check_val("sat_main_34", int'(stall_cnt_o), 17);
      end
    end
    nop();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Produces the 2-bit `select_i` codes for the EX-stage ALU operand 3-to-1 muxes (operand A and operand B).
- Also produces the load-use stall of the 5-stage pipelined CPU.
- Tracks destination/control info of the instructions in EX, MEM and WB internally, so the top level only feeds ID-stage fields plus flush.
- The encoding is fixed by the mux: 00 = register-file value (data0), 01 = MEM/WB result (data1), 10 = EX/MEM result (data2).

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous active-low reset.
- id_rs_i  input  REG_ADDR_W  rs of the instruction in ID.
- id_rt_i  input  REG_ADDR_W  rt of the instruction in ID.
- id_uses_rt_i  input  1  ID instruction reads rt as a source (R-type, branch, store).
- id_rd_i  input  REG_ADDR_W  final destination of the ID instruction (rd/rt already selected).
- id_reg_write_i  input  1  ID instruction writes the register file.
- id_mem_read_i  input  1  ID instruction is a load.
- flush_i  input  1  squash the ID instruction (taken branch/jump).
- fwd_a_o  output  2  select for ALU operand A mux.
- fwd_b_o  output  2  select for ALU operand B mux.
- stall_o  output  1  hold PC and IF/ID; bubble into EX.
- stall_cnt_o  output  CNT_W  number of stall cycles since reset.

Behaviour:
- **Internal stage registers:**
  - EX: rs, rt, rd, rw, mr.
  - MEM: rd, rw, mr.
  - WB: rd, rw.
- **Reset:** while rst_i=0, all stage registers and stall_cnt_o are 0. The outputs therefore read fwd_a_o=00, fwd_b_o=00, stall_o=0. Reset asserted mid-operation clears everything immediately, with no clock needed.
- **Advance every rising edge:**
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields, unless stall_o=1 or flush_i=1. In that case EX<=bubble: all fields 0, rw=0, mr=0.
  - Stall and flush in the same cycle give one bubble; flush has no additional effect.
- **Forwarding (combinational from stage registers):**
  - fwd_a_o=10 if MEM.rw && MEM.rd!=0 && MEM.rd==EX.rs.
  - else fwd_a_o=01 if WB.rw && WB.rd!=0 && WB.rd==EX.rs.
  - else fwd_a_o=00.
  - fwd_b_o uses the same rule against EX.rt.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
  - Code 11 is never driven, because the mux leaves data_o undefined for it.
  - EX.rt forwarding is computed even when the EX instruction uses an immediate; the downstream ALUSrc mux discards it.
- **Load-use stall (combinational):**
  - stall_o=1 iff EX.mr && EX.rd!=0 && (EX.rd==id_rs_i || (id_uses_rt_i && EX.rd==id_rt_i)).
  - A single stall lasts exactly 1 cycle. The next cycle, the load is in MEM and EX holds the bubble (mr=0), so stall_o drops.
  - The dependent instruction then enters EX with the load in WB, giving select 01.
- **Counter:**
  - stall_cnt_o increments by 1 on each rising edge where stall_o=1.
  - It saturates at all-ones and never wraps.
- **Scope limit:** instructions 3 apart rely on the register file's write-before-read; no forwarding is done for that case.

Test Plan:
1. **Reset:** hold rst_i=0 with random ID inputs -> fwd_a_o=00, fwd_b_o=00, stall_o=0, stall_cnt_o=0. Assert rst_i=0 mid-stream -> same values immediately, before the next edge.
2. **Back-to-back ALU dependency:** add $3 then sub $5,$3,$3 -> with sub in EX, fwd_a_o=10 and fwd_b_o=10.
   - Insert one independent instruction between them -> with sub in EX, fwd_a_o=01 and fwd_b_o=01.
3. **Priority:** add $3; add $3; or $6,$3,$0 -> with or in EX, fwd_a_o=10 (newest value), fwd_b_o=00.
4. **Load-use:** lw $4 then add $7,$4,$2 ->
   - stall_o=1 for exactly 1 cycle, then an EX bubble.
   - With add in EX: fwd_a_o=01, stall_cnt_o=1.
   - Variant with lw $4 then addi $7,$2,4 (id_uses_rt_i=0, rt=4) -> no stall.
5. **Register zero and flush:**
   - Writes to $0 followed by a $0 reader -> selects stay 00.
   - flush_i=1 on lw $4 in ID, then an add $4 reader -> no stall, no forward.
   - flush_i=1 together with stall_o=1 -> one bubble only.
6. **Counter saturation:** with CNT_W=4, force 17 stall cycles -> stall_cnt_o stops at 4'hF and does not wrap to 0.
